// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, starvation limit default and FSM encoding for the memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_LIMIT_DEF = 3;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT_I = 3'd1;
  localparam logic [2:0] S_GRANT_D = 3'd2;
  localparam logic [2:0] S_DONE_I  = 3'd3;
  localparam logic [2:0] S_DONE_D  = 3'd4;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: D-over-I winner selection with a saturating starvation counter protecting I
module mem_arb_select import mem_arbiter_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic grant_i,
  output logic pick_d_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] cnt_q, cnt_d;
  logic starved;
  always_comb begin
    starved  = cnt_q == CW'(STARVE_LIMIT);
    pick_d_o = d_req_i && !(i_req_i && starved);
    cnt_d    = !i_req_i ? '0 : !grant_i ? cnt_q : !pick_d_o ? '0 : starved ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter in front of a single busywait memory
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic d_req, start, pick_d, in_grant, done;
  assign d_req    = D_READ || D_WRITE;
  assign start    = state_q == S_IDLE && (I_READ || d_req);
  assign in_grant = state_q == S_GRANT_I || state_q == S_GRANT_D;
  assign done     = in_grant && !M_BUSYWAIT;
  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .i_req_i  (I_READ),
    .d_req_i  (d_req),
    .grant_i  (start),
    .pick_d_o (pick_d)
  );
  // Grant states hold until memory completes; every other state falls back to IDLE.
  always_comb begin
    state_d   = in_grant ? state_q : S_IDLE;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (start) begin
      state_d = pick_d ? S_GRANT_D : S_GRANT_I;
      addr_d  = pick_d ? D_ADDRESS : I_ADDRESS;
      wdata_d = pick_d ? D_WRITEDATA : '0;
      wr_d    = pick_d && D_WRITE;
      rd_d    = !(pick_d && D_WRITE);
    end
    if (done) begin
      state_d   = state_q == S_GRANT_D ? S_DONE_D : S_DONE_I;
      i_rdata_d = (rd_q && state_q == S_GRANT_I) ? M_READDATA : i_rdata_q;
      d_rdata_d = (rd_q && state_q == S_GRANT_D) ? M_READDATA : d_rdata_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign M_READ      = in_grant && rd_q;
  assign M_WRITE     = in_grant && wr_q;
  assign M_ADDRESS   = in_grant ? addr_q : '0;
  assign M_WRITEDATA = in_grant ? wdata_q : '0;
  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;
  assign I_BUSYWAIT  = I_READ && state_q != S_DONE_I;
  assign D_BUSYWAIT  = d_req && state_q != S_DONE_D;
endmodule
